// File: rtl/ddr3_read_ring_buffer.sv
// Read-return capture ring for the DDR3 read path: frames BL8/BC4 bursts of
// strobe-aligned beat pairs after a listen pulse and drains them one word per rd_en.
module ddr3_read_ring_buffer #(
    parameter int DW      = 16,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 32,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          listen,
    input  logic          bc4,
    input  logic          cap_valid,
    input  logic [DW-1:0] din_rise,
    input  logic [DW-1:0] din_fall,
    input  logic          rd_en,
    input  logic          flush,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level,
    output logic          busy,
    output logic          overflow,
    output logic          timeout,
    output logic          listen_err,
    output logic [1:0]    fsm_state
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARMED   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam int         TW      = $clog2(TIMEOUT + 1);

    logic [1:0]    state;
    logic [2:0]    pairs_left;
    logic [TW-1:0] timer;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [DW-1:0] ring [DEPTH];

    logic          pop;
    logic          pair;
    logic          push;
    logic [AW:0]   free;
    logic [AW:0]   level_next;

    // Handshake: rd_en is a request honoured only while !empty (and not in a
    // flush cycle); dout_valid is high exactly one cycle after an honoured pop.
    always_comb begin
        pop        = rd_en && !empty && !flush;
        pair       = cap_valid && (state != IDLE) && !flush;
        free       = (AW+1)'(DEPTH) - level + (AW+1)'(pop);
        push       = pair && (free >= (AW+1)'(2));
        level_next = level + (push ? (AW+1)'(2) : '0) - (AW+1)'(pop);
    end

    assign busy      = (state != IDLE);
    assign fsm_state = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pairs_left <= '0;
            timer      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            empty      <= 1'b1;
            full       <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            timeout    <= 1'b0;
            listen_err <= 1'b0;
        end else if (flush) begin
            state      <= IDLE;
            pairs_left <= '0;
            timer      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            empty      <= 1'b1;
            full       <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            timeout    <= 1'b0;
            listen_err <= 1'b0;
        end else begin
            dout_valid <= pop;
            if (pop) begin
                dout   <= ring[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(2);
            end
            // A pair without room is dropped whole; framing still advances below.
            if (pair && !push) begin
                overflow <= 1'b1;
            end
            level <= level_next;
            empty <= (level_next == '0);
            full  <= (level_next > (AW+1)'(DEPTH - 2));
            if (listen && state != IDLE) begin
                listen_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (listen) begin
                        state      <= ARMED;
                        pairs_left <= bc4 ? 3'd2 : 3'd4;
                        timer      <= TW'(TIMEOUT);
                    end
                end
                ARMED: begin
                    if (cap_valid) begin
                        pairs_left <= pairs_left - 3'd1;
                        state      <= (pairs_left == 3'd1) ? IDLE : CAPTURE;
                    end else if (timer == TW'(1)) begin
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                CAPTURE: begin
                    if (cap_valid) begin
                        pairs_left <= pairs_left - 3'd1;
                        if (pairs_left == 3'd1) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Ring contents survive reset and flush; only the pointers are cleared.
    always_ff @(posedge clock) begin
        if (push) begin
            ring[wr_ptr]          <= din_rise;
            ring[wr_ptr + AW'(1)] <= din_fall;
        end
    end

endmodule

// File: tb/tb_ddr3_read_ring_buffer.sv
// Self-checking bench for ddr3_read_ring_buffer: directed scenarios plus random
// traffic, compared against a queue-based burst model.
module tb_ddr3_read_ring_buffer;

    localparam int DW      = 16;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 32;
    localparam int AW      = 4;

    logic          clock;
    logic          reset;
    logic          listen;
    logic          bc4;
    logic          cap_valid;
    logic [DW-1:0] din_rise;
    logic [DW-1:0] din_fall;
    logic          rd_en;
    logic          flush;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          empty;
    logic          full;
    logic [AW:0]   level;
    logic          busy;
    logic          overflow;
    logic          timeout;
    logic          listen_err;
    logic [1:0]    fsm_state;

    int errors = 0;
    int checks = 0;

    // Reference model: stored words, pairs still owed by the current burst,
    // whether the first pair is still awaited, and the remaining wait budget.
    logic [DW-1:0] exp_q[$];
    int            m_pairs;
    bit            m_armed;
    int            m_wait;
    bit            m_ovf, m_to, m_lerr, m_dv;
    logic [DW-1:0] m_dout;

    ddr3_read_ring_buffer #(.DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .listen(listen), .bc4(bc4),
        .cap_valid(cap_valid), .din_rise(din_rise), .din_fall(din_fall),
        .rd_en(rd_en), .flush(flush), .dout(dout), .dout_valid(dout_valid),
        .empty(empty), .full(full), .level(level), .busy(busy),
        .overflow(overflow), .timeout(timeout), .listen_err(listen_err),
        .fsm_state(fsm_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_clear();
        exp_q.delete();
        m_pairs = 0;
        m_armed = 0;
        m_wait  = 0;
        m_ovf   = 0;
        m_to    = 0;
        m_lerr  = 0;
        m_dv    = 0;
        m_dout  = '0;
    endtask

    // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
    task automatic tick(input bit l, input bit b, input bit c, input logic [DW-1:0] r,
                        input logic [DW-1:0] f, input bit rd, input bit fl);
        bit pop;
        bit was_busy;
        listen = l; bc4 = b; cap_valid = c; din_rise = r; din_fall = f;
        rd_en = rd; flush = fl;
        if (fl) begin
            model_clear();
        end else begin
            pop      = rd && (exp_q.size() > 0);
            was_busy = (m_pairs > 0);
            m_dv     = pop;
            if (pop) m_dout = exp_q.pop_front();
            if (l && was_busy) m_lerr = 1;
            if (was_busy && c) begin
                if (DEPTH - exp_q.size() >= 2) begin
                    exp_q.push_back(r);
                    exp_q.push_back(f);
                end else begin
                    m_ovf = 1;
                end
                m_pairs--;
                m_armed = 0;
            end else if (was_busy && m_armed) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_to    = 1;
                    m_pairs = 0;
                    m_armed = 0;
                end
            end
            if (l && !was_busy) begin
                m_pairs = b ? 2 : 4;
                m_armed = 1;
                m_wait  = TIMEOUT;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        tick(0, 0, 0, '0, '0, 0, 0);
    endtask

    task automatic rand_burst(input bit b);
        tick(1, b, 0, '0, '0, 0, 0);
        for (int i = 0; i < (b ? 2 : 4); i++)
            tick(0, 0, 1, DW'($urandom), DW'($urandom), 0, 0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        model_clear();
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if ({overflow, timeout, listen_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {overflow, timeout, listen_err}); end
        checks++; if (dout_valid !== 1'b0 || dout !== 16'h0) begin errors++; $display("FAIL reset_dout: got %b/%h want 0/0000", dout_valid, dout); end
    endtask

    task automatic test_bl8();
        logic [DW-1:0] w [8] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                                 16'h5555, 16'h6666, 16'h7777, 16'h8888};
        tick(1, 0, 0, '0, '0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 1, w[2*i], w[2*i+1], 0, 0);
            checks++; if (busy !== (i < 3)) begin errors++; $display("FAIL bl8_busy[%0d]: got %b want %b", i, busy, (i < 3)); end
        end
        checks++; if (level !== 5'd8) begin errors++; $display("FAIL bl8_level: got %0d want 8", level); end
        for (int k = 0; k < 8; k++) begin
            tick(0, 0, 0, '0, '0, 1, 0);
            checks++; if (dout_valid !== 1'b1 || dout !== w[k]) begin errors++; $display("FAIL bl8_dout[%0d]: got %b/%h want 1/%h", k, dout_valid, dout, w[k]); end
        end
        checks++; if (empty !== 1'b1 || level !== 5'd0) begin errors++; $display("FAIL bl8_empty: got %b/%0d want 1/0", empty, level); end
        idle();
        checks++; if (dout_valid !== 1'b0 || dout !== 16'h8888) begin errors++; $display("FAIL bl8_hold: got %b/%h want 0/8888", dout_valid, dout); end
    endtask

    task automatic test_bc4_extra();
        tick(0, 0, 0, '0, '0, 0, 1);
        tick(1, 1, 0, '0, '0, 0, 0);
        for (int i = 0; i < 4; i++)
            tick(0, 0, 1, DW'($urandom), DW'($urandom), 0, 0);
        checks++; if (level !== 5'd4 || 5'(exp_q.size()) !== 5'd4) begin errors++; $display("FAIL bc4_level: got %0d want 4", level); end
        checks++; if ({overflow, timeout, listen_err, busy} !== 4'b0000) begin errors++; $display("FAIL bc4_flags: got %b want 0000", {overflow, timeout, listen_err, busy}); end
        for (int k = 0; k < 4; k++) begin
            tick(0, 0, 0, '0, '0, 1, 0);
            checks++; if (dout_valid !== 1'b1 || dout !== m_dout) begin errors++; $display("FAIL bc4_dout[%0d]: got %b/%h want 1/%h", k, dout_valid, dout, m_dout); end
        end
    endtask

    task automatic test_overflow();
        tick(0, 0, 0, '0, '0, 0, 1);
        rand_burst(0);
        rand_burst(0);
        checks++; if (level !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_fill: got %0d/%b/%b want 16/1/0", level, full, overflow); end
        rand_burst(0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        checks++; if (level !== 5'd16 || busy !== 1'b0) begin errors++; $display("FAIL ovf_level_busy: got %0d/%b want 16/0", level, busy); end
        for (int k = 0; k < 16; k++) begin
            tick(0, 0, 0, '0, '0, 1, 0);
            checks++; if (dout_valid !== 1'b1 || dout !== m_dout) begin errors++; $display("FAIL ovf_dout[%0d]: got %b/%h want 1/%h", k, dout_valid, dout, m_dout); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_empty: got %b want 1", empty); end
    endtask

    task automatic test_timeout_listen_err();
        tick(0, 0, 0, '0, '0, 0, 1);
        tick(1, 0, 0, '0, '0, 0, 0);
        repeat (TIMEOUT - 1) idle();
        checks++; if (busy !== 1'b1 || timeout !== 1'b0) begin errors++; $display("FAIL to_early: got busy=%b to=%b want 1/0", busy, timeout); end
        idle();
        checks++; if (busy !== 1'b0 || timeout !== 1'b1) begin errors++; $display("FAIL to_expire: got busy=%b to=%b want 0/1", busy, timeout); end
        tick(1, 0, 0, '0, '0, 0, 0);
        tick(0, 0, 1, DW'($urandom), DW'($urandom), 0, 0);
        tick(1, 1, 0, '0, '0, 0, 0);
        tick(0, 0, 1, DW'($urandom), DW'($urandom), 0, 0);
        tick(0, 0, 1, DW'($urandom), DW'($urandom), 0, 0);
        // Final pair arrives together with a listen: error, and no re-arm.
        tick(1, 0, 1, DW'($urandom), DW'($urandom), 0, 0);
        checks++; if (listen_err !== 1'b1 || timeout !== 1'b1) begin errors++; $display("FAIL lerr_flags: got lerr=%b to=%b want 1/1", listen_err, timeout); end
        checks++; if (level !== 5'd8 || busy !== 1'b0) begin errors++; $display("FAIL lerr_burst: got %0d/%b want 8/0", level, busy); end
        for (int k = 0; k < 8; k++) begin
            tick(0, 0, 0, '0, '0, 1, 0);
            checks++; if (dout_valid !== 1'b1 || dout !== m_dout) begin errors++; $display("FAIL lerr_dout[%0d]: got %b/%h want 1/%h", k, dout_valid, dout, m_dout); end
        end
    endtask

    task automatic test_wrap();
        tick(0, 0, 0, '0, '0, 0, 1);
        rand_burst(0);
        rand_burst(1);
        checks++; if (level !== 5'd12) begin errors++; $display("FAIL wrap_prefill: got %0d want 12", level); end
        // This burst lands in entries 12,14,0,2 while the ring drains every cycle.
        tick(1, 0, 0, '0, '0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            tick(0, 0, (i % 2) == 0, DW'($urandom), DW'($urandom), 1, 0);
            checks++; if (level !== 5'(exp_q.size()) || overflow !== 1'b0 || full !== (exp_q.size() > DEPTH - 2)) begin
                errors++; $display("FAIL wrap_level[%0d]: got %0d/%b/%b want %0d/0/%b", i, level, overflow, full, exp_q.size(), (exp_q.size() > DEPTH - 2));
            end
            checks++; if (dout_valid !== 1'b1 || dout !== m_dout) begin errors++; $display("FAIL wrap_rw_dout[%0d]: got %b/%h want 1/%h", i, dout_valid, dout, m_dout); end
        end
        while (exp_q.size() > 0) begin
            tick(0, 0, 0, '0, '0, 1, 0);
            checks++; if (dout_valid !== 1'b1 || dout !== m_dout) begin errors++; $display("FAIL wrap_dout: got %b/%h want 1/%h", dout_valid, dout, m_dout); end
        end
    endtask

    task automatic test_reset_flush_mid();
        tick(0, 0, 0, '0, '0, 0, 1);
        tick(1, 0, 0, '0, '0, 0, 0);
        repeat (2) tick(0, 0, 1, DW'($urandom), DW'($urandom), 0, 0);
        reset = 1'b1;
        #1;
        checks++; if (level !== 5'd0 || empty !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL arst_state: got %0d/%b/%b want 0/1/0", level, empty, busy); end
        checks++; if ({overflow, timeout, listen_err, dout_valid} !== 4'b0000) begin errors++; $display("FAIL arst_flags: got %b want 0000", {overflow, timeout, listen_err, dout_valid}); end
        reset = 1'b0;
        model_clear();
        repeat (2) tick(0, 0, 1, DW'($urandom), DW'($urandom), 0, 0);
        checks++; if (level !== 5'd0 || busy !== 1'b0) begin errors++; $display("FAIL arst_after: got %0d/%b want 0/0", level, busy); end

        tick(1, 0, 0, '0, '0, 0, 0);
        repeat (2) tick(0, 0, 1, DW'($urandom), DW'($urandom), 0, 0);
        tick(1, 0, 1, DW'($urandom), DW'($urandom), 1, 1);
        checks++; if (level !== 5'd0 || empty !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL flush_state: got %0d/%b/%b want 0/1/0", level, empty, busy); end
        checks++; if ({overflow, timeout, listen_err, dout_valid} !== 4'b0000) begin errors++; $display("FAIL flush_flags: got %b want 0000", {overflow, timeout, listen_err, dout_valid}); end
        repeat (2) tick(0, 0, 1, DW'($urandom), DW'($urandom), 0, 0);
        checks++; if (level !== 5'd0 || busy !== 1'b0) begin errors++; $display("FAIL flush_after: got %0d/%b want 0/0", level, busy); end
    endtask

    task automatic test_random();
        tick(0, 0, 0, '0, '0, 0, 1);
        for (int n = 0; n < 800; n++) begin
            tick($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 DW'($urandom), DW'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);
            checks++;
            if ({level, empty, full, busy, overflow, timeout, listen_err, dout_valid} !==
                {5'(exp_q.size()), exp_q.size() == 0, exp_q.size() > DEPTH - 2, m_pairs > 0,
                 m_ovf, m_to, m_lerr, m_dv}) begin
                errors++;
                $display("FAIL rand_status[%0d]: got lvl=%0d e=%b f=%b b=%b o=%b t=%b l=%b v=%b want lvl=%0d o=%b t=%b l=%b v=%b",
                         n, level, empty, full, busy, overflow, timeout, listen_err, dout_valid,
                         exp_q.size(), m_ovf, m_to, m_lerr, m_dv);
            end
            checks++; if (dout !== m_dout) begin errors++; $display("FAIL rand_dout[%0d]: got %h want %h", n, dout, m_dout); end
        end
    endtask

    initial begin
        reset = 1'b1; listen = 0; bc4 = 0; cap_valid = 0; din_rise = '0;
        din_fall = '0; rd_en = 0; flush = 0;
        model_clear();
        test_reset();
        test_bl8();
        test_bc4_extra();
        test_overflow();
        test_timeout_listen_err();
        test_wrap();
        test_reset_flush_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
